// File: rtl/vram_cpu_port_if.sv
// Z80-side bus bundle for the tile-RAM CPU port: decoded memory cycle in,
// read data, window select and WAIT back out.
interface vram_cpu_port_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_mreq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_rdata;
    logic        cpu_sel;
    logic        cpu_wait_n;

    modport master (
        output cpu_addr, cpu_wdata, cpu_mreq_n, cpu_rd_n, cpu_wr_n,
        input  cpu_rdata, cpu_sel, cpu_wait_n
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_mreq_n, cpu_rd_n, cpu_wr_n,
        output cpu_rdata, cpu_sel, cpu_wait_n
    );
endinterface

// File: rtl/vram_cpu_port.sv
// CPU initiator for the tile RAM: turns Z80 cycles in the 1 KiB window into
// single-cycle rdn/wrn strobes, holding WAIT while the video side owns VRAM.
module vram_cpu_port #(
    parameter logic [15:0] BASE_ADDR = 16'h7400,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    vram_cpu_port_if.slave   cpu,
    input  logic             i_cmpblk,
    input  logic             i_vram_busy,
    input  logic [7:0]       i_vram_rdata,
    output logic [9:0]       o_vram_addr,
    output logic [7:0]       o_vram_wdata,
    output logic             o_vram_rdn,
    output logic             o_vram_wrn,
    output logic             o_vram_ena,
    output logic             o_timeout_err
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITW,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_dir_wr;
    logic [9:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        r_rdn;
    logic        r_wrn;
    logic        r_ena;
    logic        r_timeout;

    logic        w_sel;
    logic        w_req;
    logic        w_win;
    logic        w_wr;
    logic [15:0] w_cnt_inc;

    assign w_sel     = (cpu.cpu_addr[15:10] == BASE_ADDR[15:10]);
    assign w_req     = w_sel & ~cpu.cpu_mreq_n & (~cpu.cpu_rd_n | ~cpu.cpu_wr_n);
    assign w_wr      = ~cpu.cpu_wr_n;
    assign w_win     = i_cmpblk & ~i_vram_busy;
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    // Strobes are set on the edge that enters ACCESS and cleared on every
    // other edge, so they come straight from flops with no decode glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_dir_wr  <= 1'b0;
            r_addr    <= 10'd0;
            r_wdata   <= 8'd0;
            r_rdata   <= 8'h00;
            r_rdn     <= 1'b1;
            r_wrn     <= 1'b1;
            r_ena     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_rdn <= 1'b1;
            r_wrn <= 1'b1;
            r_ena <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr   <= cpu.cpu_addr[9:0];
                        r_wdata  <= cpu.cpu_wdata;
                        r_dir_wr <= w_wr;
                        r_cnt    <= 16'd0;
                        if (w_win) begin
                            r_state <= S_ACCESS;
                            r_ena   <= 1'b1;
                            r_rdn   <= w_wr;
                            r_wrn   <= ~w_wr;
                        end else begin
                            r_state <= S_WAITW;
                        end
                    end
                end
                S_WAITW: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_win) begin
                            r_state <= S_ACCESS;
                            r_ena   <= 1'b1;
                            r_rdn   <= r_dir_wr;
                            r_wrn   <= ~r_dir_wr;
                        end else if (w_cnt_inc >= TO_LIM) begin
                            // Abandoned: a read returns FF, a write is dropped.
                            r_timeout <= 1'b1;
                            r_rdata   <= 8'hFF;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!w_req)
                        r_state <= S_IDLE;
                    else if (!i_cmpblk)
                        r_state <= S_WAITW;
                    else if (r_dir_wr)
                        r_state <= S_DONE;
                    else
                        r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_rdata <= i_vram_rdata;
                    r_state <= w_req ? S_DONE : S_IDLE;
                end
                S_DONE: begin
                    if (!w_req)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // WAIT must drop in the same cycle the request shows up, hence combinational.
    assign cpu.cpu_wait_n = ~(rst_n & w_req & (r_state != S_DONE));
    assign cpu.cpu_sel    = w_sel;
    assign cpu.cpu_rdata  = r_rdata;

    assign o_vram_addr    = r_addr;
    assign o_vram_wdata   = r_wdata;
    assign o_vram_rdn     = r_rdn;
    assign o_vram_wrn     = r_wrn;
    assign o_vram_ena     = r_ena;
    assign o_timeout_err  = r_timeout;

endmodule
